// File: rtl/frag_writer.sv
// Pops generator fragments, clips them to the framebuffer and writes one flat-colour pixel per survivor.
// Pop-to-request is 2 cycles (3 per written pixel); a stalled mem_ack holds the block in WRITE with no further pops.
module frag_writer #(
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] color,
  input  logic [31:0] fb_base,
  input  logic        frag_val,
  input  logic [31:0] frag_x,
  input  logic [31:0] frag_y,
  output logic        pop_frag,
  input  logic        raster_done,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic        mem_ack,
  output logic        ready,
  output logic        done,
  output logic [31:0] frag_count,
  output logic [31:0] clip_count
);

  typedef enum logic [2:0] {IDLE, ACCEPT, CHECK, WRITE, FINISH} state_t;

  state_t      state, state_nxt;
  logic [31:0] color_q, base_q, x_q, y_q;
  logic [31:0] pix_off;
  logic        seen_done;
  logic        in_range;
  logic        write_ack;

  assign in_range  = (x_q < FB_WIDTH) && (y_q < FB_HEIGHT);
  assign pix_off   = (y_q * FB_WIDTH + x_q) << 2;
  assign write_ack = mem_req && mem_ack;

  always_comb begin
    state_nxt = state;
    pop_frag  = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = ACCEPT;
      ACCEPT: begin
        // A queued fragment always wins over completion so the FIFO drains fully.
        if (frag_val) begin
          pop_frag  = !rst;
          state_nxt = CHECK;
        end else if (seen_done || raster_done) begin
          state_nxt = FINISH;
        end
      end
      CHECK:  state_nxt = in_range ? WRITE : ACCEPT;
      WRITE:  if (write_ack) state_nxt = ACCEPT;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b0;
      mem_req    <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      frag_count <= '0;
      clip_count <= '0;
      color_q    <= '0;
      base_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      seen_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready   <= (state_nxt == IDLE);
      mem_req <= (state_nxt == WRITE);
      done    <= (state_nxt == FINISH);
      if (state != IDLE && raster_done) seen_done <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            color_q    <= color;
            base_q     <= fb_base;
            frag_count <= '0;
            clip_count <= '0;
            seen_done  <= 1'b0;
          end
        end
        ACCEPT: begin
          if (frag_val) begin
            x_q <= frag_x;
            y_q <= frag_y;
          end
        end
        CHECK: begin
          if (in_range) begin
            mem_addr <= base_q + pix_off;
            mem_data <= color_q;
          end else begin
            clip_count <= clip_count + 32'd1;
          end
        end
        WRITE: if (write_ack) frag_count <= frag_count + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frag_writer.sv
// Scoreboarded bench for frag_writer: a fragment FIFO model feeds the DUT, expected writes/completions are queued at issue time.
module tb_frag_writer;

  localparam int FBW = 640;
  localparam int FBH = 480;

  logic        clk = 1'b0;
  logic        rst, start, frag_val, raster_done, mem_ack;
  logic [31:0] color, fb_base, frag_x, frag_y;
  logic        pop_frag, mem_req, ready, done;
  logic [31:0] mem_addr, mem_data, frag_count, clip_count;

  frag_writer #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH)) dut (
    .clk(clk), .rst(rst), .start(start), .color(color), .fb_base(fb_base),
    .frag_val(frag_val), .frag_x(frag_x), .frag_y(frag_y), .pop_frag(pop_frag),
    .raster_done(raster_done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .ready(ready), .done(done),
    .frag_count(frag_count), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] x; logic [31:0] y; } frag_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] w; logic [31:0] c; } dn_t;

  frag_t fq[$];
  wr_t   exp_q[$];
  dn_t   done_q[$];
  int    pop_cyc[$];

  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, done_target = 0;
  int done_cyc = 0, last_ack_cyc = 0;
  int ack_mode = 0, ack_dly = 0, wcnt = 0;
  logic        pend_pop = 1'b0, prev_req = 1'b0;
  logic [31:0] cur_b, cur_c, tri_w, tri_c;
  frag_t fhead;
  wr_t   e;
  dn_t   d;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Generator FIFO: retire the head popped at the last edge, then present the new head.
  always begin
    @(negedge clk);
    if (pend_pop && fq.size() > 0) fq.delete(0);
    if (fq.size() > 0) begin
      fhead = fq[0];
      frag_val = 1'b1; frag_x = fhead.x; frag_y = fhead.y;
    end else begin
      frag_val = 1'b0; frag_x = $urandom; frag_y = $urandom;
    end
    #1;
    pend_pop = pop_frag;
  end

  // Memory responder: 0 = ack tied high, 1 = ack after ack_dly stalled cycles, 2 = random.
  always begin
    @(negedge clk);
    if (mem_req) begin
      wcnt++;
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = (wcnt > ack_dly);
        default: mem_ack = ($urandom_range(0, 2) == 0);
      endcase
    end else begin
      wcnt = 0;
      mem_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: compares every write-request cycle and every done pulse against the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (pop_frag) begin
        chk("pop_needs_frag_val", frag_val, 1);
        pop_cyc.push_back(cyc);
      end
      if (mem_req) begin
        chk("no_pop_during_write", pop_frag, 0);
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_data", mem_data, e.data);
          if (mem_ack) begin
            exp_q.delete(0);
            last_ack_cyc = cyc;
          end
        end
        if (ack_mode == 0) chk("req_back_to_back", prev_req, 0);
      end
      if (done) begin
        done_cyc = cyc;
        n_done++;
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("done_frag_count", frag_count, d.w);
          chk("done_clip_count", clip_count, d.c);
          chk("done_writes_pending", exp_q.size(), 0);
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic begin_tri(logic [31:0] b, logic [31:0] c, logic rd);
    int k = 0;
    while (!ready && k < 500) begin @(negedge clk); k++; end
    chk("ready_before_start", ready, 1);
    start = 1'b1; color = c; fb_base = b; raster_done = rd;
    cur_b = b; cur_c = c; tri_w = 0; tri_c = 0;
    @(negedge clk);
    start = 1'b0; raster_done = 1'b0; color = $urandom; fb_base = $urandom;
  endtask

  // Reference model: a fragment inside the framebuffer becomes one 32-bit write at base + 4*(y*W + x).
  task automatic push_frag(logic [31:0] x, logic [31:0] y);
    frag_t  f;
    wr_t    w;
    longint off;
    f.x = x; f.y = y;
    fq.push_back(f);
    if (x < FBW && y < FBH) begin
      off = (longint'(y) * FBW + longint'(x)) * 4;
      w.addr = cur_b + off[31:0];
      w.data = cur_c;
      exp_q.push_back(w);
      tri_w++;
    end else begin
      tri_c++;
    end
  endtask

  task automatic expect_done();
    dn_t x;
    x.w = tri_w; x.c = tri_c;
    done_q.push_back(x);
    done_target++;
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done < done_target && k < 3000) begin @(negedge clk); k++; end
    chk("done_seen", n_done >= done_target, 1);
  endtask

  task automatic end_tri();
    expect_done();
    raster_done = 1'b1;
    @(negedge clk);
    raster_done = 1'b0;
    wait_done();
  endtask

  task automatic wait_req();
    int k = 0;
    while (!mem_req && k < 200) begin @(negedge clk); k++; end
    chk("mem_req_seen", mem_req, 1);
  endtask

  initial begin
    logic [31:0] fc, cc, x, y;
    int n;
    rst = 1'b1; start = 1'b0; color = '0; fb_base = '0; raster_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_pop", pop_frag, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_frag_count", frag_count, 0);
    chk("rst_clip_count", clip_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);

    // Single in-range fragment.
    ack_mode = 0;
    begin_tri(32'h0000_1000, 32'hFF00_FF00, 1'b0);
    push_frag(3, 2);
    end_tri();
    chk("t1_done_latency", (done_cyc - last_ack_cyc) <= 2, 1);

    // Framebuffer edges and clipping.
    begin_tri(32'h0004_0000, 32'h1234_5678, 1'b0);
    push_frag(639, 479);
    push_frag(640, 0);
    push_frag(0, 480);
    push_frag(32'hFFFF_FFFF, 5);
    end_tri();

    // Back-to-back fragments with ack tied high.
    begin_tri(32'h8000_0000, 32'hA5A5_5A5A, 1'b0);
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) push_frag(i * 7, i * 3);
    end_tri();
    chk("t3_pop_count", pop_cyc.size(), 8);
    for (int i = 1; i < pop_cyc.size(); i++) chk("t3_pop_gap", pop_cyc[i] - pop_cyc[i-1], 3);
    chk("t3_done_latency", (done_cyc - last_ack_cyc) <= 2, 1);

    // Stalled ack with raster_done arriving mid-stall.
    ack_mode = 1; ack_dly = 5;
    begin_tri(32'h0010_0000, 32'hDEAD_BEEF, 1'b0);
    push_frag(100, 200);
    wait_req();
    n = 0;
    while (mem_req && n < 50) begin
      if (n == 2) expect_done();
      raster_done = (n == 2);
      n++;
      @(negedge clk);
    end
    raster_done = 1'b0;
    chk("t4_stall_len", n, 6);
    wait_done();
    chk("t4_done_after_ack", done_cyc > last_ack_cyc, 1);

    // start during WRITE and raster_done in IDLE are both ignored.
    ack_mode = 1; ack_dly = 3;
    begin_tri(32'h0020_0000, 32'h0BAD_F00D, 1'b0);
    push_frag(1, 1);
    push_frag(2, 2);
    wait_req();
    start = 1'b1; color = 32'h1111_1111; fb_base = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    end_tri();
    @(negedge clk);
    fc = frag_count; cc = clip_count;
    raster_done = 1'b1;
    @(negedge clk);
    raster_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_idle_rd_frag_count", frag_count, fc);
    chk("t5_idle_rd_clip_count", clip_count, cc);
    chk("t5_idle_rd_ready", ready, 1);
    ack_mode = 0;
    begin_tri(32'h0030_0000, 32'h7777_0000, 1'b1);
    repeat (4) @(negedge clk);
    push_frag(5, 6);
    end_tri();

    // Reset while a write is outstanding.
    ack_mode = 1; ack_dly = 100;
    begin_tri(32'h0040_0000, 32'hCAFE_BABE, 1'b0);
    push_frag(10, 10);
    wait_req();
    repeat (2) @(negedge clk);
    chk("t6_req_before_rst", mem_req, 1);
    rst = 1'b1;
    exp_q.delete();
    fq.delete();
    @(negedge clk);
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_frag_count", frag_count, 0);
    chk("t6_rst_clip_count", clip_count, 0);
    chk("t6_rst_ready", ready, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    rst = 1'b0; ack_mode = 0;
    @(negedge clk);
    chk("t6_ready_after_rst", ready, 1);
    begin_tri(32'h0050_0000, 32'h0102_0304, 1'b0);
    push_frag(20, 30);
    push_frag(700, 30);
    end_tri();

    // Randomised triangles with a random responder.
    ack_mode = 2;
    for (int t = 0; t < 10; t++) begin
      begin_tri($urandom, $urandom, 1'b0);
      n = (t == 0) ? 0 : $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        x = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 700));
        y = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 520));
        push_frag(x, y);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      repeat ($urandom_range(0, 6)) @(negedge clk);
      end_tri();
    end

    repeat (3) @(negedge clk);
    chk("final_no_stray_writes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
